// File: rtl/lsu_mem_ctrl.sv
// LSU back-end: one EX request -> one 64-bit memory access -> one WB response.
// Ports: req_* in, resp_* out, men/mwen/raddr/rdata/waddr/wdata/wmask to memory.
// Optional: `define MISALIGN_TRAP_EN to flag misaligned requests instead of issuing them.
module lsu_mem_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              men,
  output logic              mwen,
  output logic [ADDR_W-1:0] raddr,
  input  logic [XLEN-1:0]   rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]   wdata,
  output logic [7:0]        wmask
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  logic              wen_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              mis;

  logic [2:0]        off;
  logic [5:0]        sh;
  logic [ADDR_W-1:0] dw_addr;
  logic [7:0]        lane_mask;
  logic [XLEN-1:0]   sh_rd;
  logic [XLEN-1:0]   ld_data;

  assign off     = addr_q[2:0];
  assign sh      = {off, 3'b000};
  assign dw_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign sh_rd   = rdata_q >> sh;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      2'd0: mis = 1'b0;
      2'd1: mis = req_addr[0];
      2'd2: mis = |req_addr[1:0];
      2'd3: mis = |req_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis   = 1'b0;
  assign err_q = 1'b0;
`endif

  always_comb begin
    lane_mask = 8'h00;
    ld_data   = '0;
    unique case (size_q)
      2'd0: begin
        lane_mask = 8'h01;
        ld_data   = {{56{sh_rd[7] & ~uns_q}}, sh_rd[7:0]};
      end
      2'd1: begin
        lane_mask = 8'h03;
        ld_data   = {{48{sh_rd[15] & ~uns_q}}, sh_rd[15:0]};
      end
      2'd2: begin
        lane_mask = 8'h0F;
        ld_data   = {{32{sh_rd[31] & ~uns_q}}, sh_rd[31:0]};
      end
      2'd3: begin
        lane_mask = 8'hFF;
        ld_data   = sh_rd;
      end
      default: begin
        lane_mask = 8'h00;
        ld_data   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        wen_q   <= req_wen;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        err_q   <= mis;
`endif
      end
      if (state == ACCESS && !wen_q) begin
        rdata_q <= rdata;
      end
`ifdef MISALIGN_TRAP_EN
      if (state == RESP && resp_ready) begin
        err_q <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    men        = 1'b0;
    mwen       = 1'b0;
    raddr      = '0;
    waddr      = '0;
    wdata      = '0;
    wmask      = 8'h00;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_n = mis ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        men     = 1'b1;
        mwen    = wen_q;
        raddr   = dw_addr;
        waddr   = dw_addr;
        wdata   = wdata_q << sh;
        wmask   = lane_mask << off;
        state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!wen_q && !err_q) begin
          resp_rdata = ld_data;
        end
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit back-end that sits directly upstream of the simulation memory port.
- Upstream side: takes one load/store request per transaction from the EX stage over a valid/ready handshake.
- Memory side: drives men/mwen, an 8-byte-aligned address, lane-shifted write data and a byte mask into the DPI memory block.
- Result: captures the 64-bit read dword, then returns sign/zero-extended load data to the WB stage over a second valid/ready handshake.

Parameters:
XLEN, 64, data path width; fixed at 64, because the memory port is 64-bit with an 8-bit mask.
ADDR_W, 64, address width.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid from EX
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_unsigned  in  1  zero-extend load result (ignored when req_size = 3)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  response valid to WB
resp_ready  in  1  WB accepts response
resp_rdata  out  XLEN  extended load data; 0 for stores
resp_err  out  1  misaligned-access error flag
men  out  1  memory enable
mwen  out  1  memory write enable
raddr  out  ADDR_W  read address, 8-byte aligned
rdata  in  XLEN  read dword from memory, combinational
waddr  out  ADDR_W  write address, 8-byte aligned
wdata  out  XLEN  lane-shifted write data
wmask  out  8  byte-lane write mask

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (async, rst_n low) forces IDLE immediately.
- Reset values:
  - req_ready = 1.
  - resp_valid, resp_err, men, mwen = 0.
  - resp_rdata, raddr, waddr, wdata, wmask = 0.
  - All internal latches = 0.
- IDLE:
  - req_ready = 1.
  - On a clock edge with req_valid = 1, latch wen, size, unsigned, addr and wdata, then go to ACCESS.
- ACCESS (exactly one cycle):
  - men = 1, mwen = wen_q.
  - raddr = waddr = {addr_q[63:3], 3'b0}.
  - off = addr_q[2:0].
  - wdata = wdata_q << (8*off).
  - wmask = (size mask 0x01/0x03/0x0F/0xFF) << off, truncated to 8 bits. Lanes beyond 7 are dropped.
  - For loads, rdata is registered into rdata_q at the end of this cycle. Then go to RESP.
- RESP:
  - resp_valid = 1.
  - Loads: resp_rdata = extend((rdata_q >> 8*off)[8<<size − 1 : 0]), sign-extended unless unsigned_q.
  - Stores: resp_rdata = 0.
  - Outputs stay stable until resp_ready = 1 at a clock edge, then go to IDLE.
- req_ready = 0 in ACCESS and RESP. There is no overlap between transactions.
- men and mwen decode only from the registered state. They are 0 in every state except ACCESS.
- Latency: accept at edge N, men high during cycle N+1, resp_valid high from cycle N+2. Minimum 3 cycles per transaction with resp_ready held high.
- Reset mid-transaction: state returns to IDLE asynchronously; men, mwen and resp_valid drop the same instant. The in-flight request is discarded.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a request whose addr is not a multiple of (1<<size) is accepted normally but skips ACCESS.
  - No men pulse.
  - Goes IDLE → RESP directly: resp_valid one cycle after accept, with resp_err = 1 and resp_rdata = 0.
  - resp_err is cleared on leaving RESP.
- Undefined: resp_err is tied to 0. Misaligned requests are issued with the truncated wmask and shifted read data described above.

Test Plan:
- Memory dword at 0x80000000 = 0x0123456789ABCDEF. LB at 0x80000003 → raddr 0x80000000, men one cycle, mwen 0, resp_rdata 0xFFFFFFFFFFFFFF89. Same access as LBU → 0x0000000000000089.
- LW at 0x80000000 (signed) → 0xFFFFFFFF89ABCDEF. LW at 0x80000004 → 0x0000000001234567. LD → 0x0123456789ABCDEF.
- SH at 0x80000006, req_wdata 0xBEEF → waddr 0x80000000, wmask 0xC0, wdata 0xBEEF000000000000, men = mwen = 1 for exactly one cycle, resp_rdata 0.
- Response backpressure: resp_ready low for 5 cycles after a load → resp_valid and resp_rdata held stable, req_ready 0, men 0 throughout. resp_ready high → IDLE next cycle, req_ready 1.
- SW at 0x80000002:
  - With MISALIGN_TRAP_EN: no men pulse, resp_valid and resp_err = 1 one cycle after accept.
  - Without: wmask 0x3C, resp_err 0.
- Assert rst_n low during ACCESS → men, mwen and resp_valid go 0 immediately, state IDLE. After release, the next LD completes normally with correct data.
